// File: rtl/bus_delay_line_if.sv
// bus_delay_line_if
//
// Purpose: bundles the sample bus and control signals of bus_delay_line
// so the source and the delay line share one connection.
//
// Signals:
//   en          pixel enable; a sample is accepted only when high
//   clr         synchronous clear, wins over en
//   delay       requested delay in enabled samples (0..MAX_DELAY-1)
//   din         input sample
//   dout        delayed sample (registered in the delay line)
//   dout_valid  one-cycle strobe, dout carries a qualified sample
//   filled      level, enough samples accepted for the current delay
//
// Modports:
//   master  the sample source / controller
//   slave   the delay line itself
interface bus_delay_line_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 16
);
    localparam int AW = $clog2(MAX_DELAY);

    logic             en;
    logic             clr;
    logic [AW-1:0]    delay;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             filled;

    modport master (
        output en,
        output clr,
        output delay,
        output din,
        input  dout,
        input  dout_valid,
        input  filled
    );

    modport slave (
        input  en,
        input  clr,
        input  delay,
        input  din,
        output dout,
        output dout_valid,
        output filled
    );
endinterface

// File: rtl/bus_delay_line.sv
// bus_delay_line
//
// Purpose: runtime-programmable delay line for a parallel video bus. Every
// enabled sample is written into a MAX_DELAY-entry ring buffer and the sample
// written D enables earlier is returned. Gaps in en stretch the latency in
// clocks but never change the delay measured in samples. Changing D while
// running restarts fill tracking so no stale or mixed data is flagged valid.
//
// Parameters:
//   WIDTH      bus width in bits
//   MAX_DELAY  ring depth, a power of two and at least 2
//
// Ports:
//   clk   single clock, all state updates on the rising edge
//   rst   asynchronous active-high reset
//   bus   bus_delay_line_if.slave carrying en, clr, delay, din (in) and
//         dout, dout_valid, filled (out)
module bus_delay_line #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 16
) (
    input  logic              clk,
    input  logic              rst,
    bus_delay_line_if.slave   bus
);
    localparam int AW = $clog2(MAX_DELAY);

    // Sample storage. Deliberately not reset: contents are only ever read
    // once fill proves they were written since the last restart.
    logic [WIDTH-1:0] mem [MAX_DELAY];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    delay_q;
    logic [AW:0]      fill;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;

    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] tap;
    logic             change;
    logic             accept;
    logic             filled_int;
    logic [AW:0]      fill_next;

    // Read tap and control decode. The read uses the pointer before this
    // cycle's write, so a delay of D returns the sample written D enables
    // ago; the subtraction wraps naturally because the depth is a power of
    // two. A delay of zero bypasses the ring and returns din directly.
    always_comb begin
        rd_ptr     = wr_ptr - delay_q;
        tap        = (delay_q == '0) ? bus.din : mem[rd_ptr];
        change     = !bus.clr && (bus.delay != delay_q);
        accept     = bus.en && !bus.clr;
        filled_int = (fill >= {1'b0, delay_q});
        fill_next  = filled_int ? {1'b0, delay_q} : (fill + 1'b1);
    end

    // Ring write. Happens on every accepted sample, including the cycle in
    // which the delay changes, so the history keeps advancing.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Pointer, fill and output state. clr restarts everything except the
    // ring contents and picks up the requested delay. A delay change zeroes
    // fill (the change-cycle write does not count) and suppresses the output
    // for that cycle, because the tap still points at the old delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            delay_q      <= '0;
            fill         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr       <= '0;
            delay_q      <= bus.delay;
            fill         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            if (change) begin
                delay_q <= bus.delay;
                fill    <= '0;
            end else if (accept) begin
                fill <= fill_next;
            end

            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (filled_int && !change) begin
                    dout_q       <= tap;
                    dout_valid_q <= 1'b1;
                end else begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end
            end else begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.filled     = filled_int;

endmodule

// File: tb/tb_bus_delay_line.sv
// tb_bus_delay_line
//
// Purpose: directed self-checking bench for bus_delay_line with WIDTH=8,
// MAX_DELAY=16. Covers reset, D=0 bypass, continuous and stalled operation,
// ring wrap, mid-stream delay change, clr and asynchronous reset.
module tb_bus_delay_line;
    logic clk;
    logic rst;

    int compared;
    int mismatched;

    bus_delay_line_if #(.WIDTH(8), .MAX_DELAY(16)) bus ();

    bus_delay_line #(.WIDTH(8), .MAX_DELAY(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected sequence end");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports each check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic e, input logic c, input logic [3:0] d,
                                 input logic [7:0] x);
        bus.en    = e;
        bus.clr   = c;
        bus.delay = d;
        bus.din   = x;
        @(posedge clk);
        #1;
    endtask

    // Checks dout and dout_valid together.
    task automatic expectBus(input string tag, input logic [7:0] d, input logic v);
        checkOutput({tag, "_dout"}, 32'(bus.dout), 32'(d));
        checkOutput({tag, "_valid"}, 32'(bus.dout_valid), 32'(v));
    endtask

    logic [7:0] stallDin [7];
    logic       stallEn  [7];

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.clr    = 1'b0;
        bus.delay  = 4'd0;
        bus.din    = 8'h00;

        // Reset state
        #3;
        expectBus("reset", 8'h00, 1'b0);
        checkOutput("reset_filled", 32'(bus.filled), 32'd1);
        #9;
        rst = 1'b0;

        // D=0 bypass: output one cycle after input, valid from the first edge
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h10);
        expectBus("d0_a", 8'h10, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h11);
        expectBus("d0_b", 8'h11, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h12);
        expectBus("d0_c", 8'h12, 1'b1);
        checkOutput("d0_filled", 32'(bus.filled), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h99);
        expectBus("d0_idle", 8'h12, 1'b0);

        // D=3, continuous ramp after a clr that loads the delay
        applyStimulus(1'b0, 1'b1, 4'd3, 8'h00);
        expectBus("d3_clr", 8'h00, 1'b0);
        checkOutput("d3_clr_filled", 32'(bus.filled), 32'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd3, 8'(i));
            if (i < 3) expectBus($sformatf("ramp%0d", i), 8'h00, 1'b0);
            else       expectBus($sformatf("ramp%0d", i), 8'(i - 3), 1'b1);
            checkOutput($sformatf("ramp%0d_filled", i), 32'(bus.filled), (i >= 2) ? 32'd1 : 32'd0);
        end

        // D=3 with stalls: only the 4th enable yields A0
        stallEn  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        stallDin = '{8'hA0, 8'hFF, 8'hFF, 8'hA1, 8'hA2, 8'hFF, 8'hA3};
        applyStimulus(1'b0, 1'b1, 4'd3, 8'h00);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(stallEn[i], 1'b0, 4'd3, stallDin[i]);
            if (i == 6) expectBus($sformatf("stall%0d", i), 8'hA0, 1'b1);
            else        expectBus($sformatf("stall%0d", i), 8'h00, 1'b0);
        end

        // D=15, 40 enables across two pointer wraps
        applyStimulus(1'b0, 1'b1, 4'd15, 8'h00);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd15, 8'(i));
            if (i < 15) expectBus($sformatf("wrap%0d", i), 8'h00, 1'b0);
            else        expectBus($sformatf("wrap%0d", i), 8'(i - 15), 1'b1);
        end

        // Running at D=2, then change to 5 with en high in the change cycle
        applyStimulus(1'b0, 1'b1, 4'd2, 8'h00);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd2, 8'(8'h40 + i));
            if (i < 2) expectBus($sformatf("d2run%0d", i), 8'h00, 1'b0);
            else       expectBus($sformatf("d2run%0d", i), 8'(8'h40 + i - 2), 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 4'd5, 8'h50);
        expectBus("chg_cycle", 8'h00, 1'b0);
        checkOutput("chg_filled", 32'(bus.filled), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd5, 8'(8'h50 + i));
            if (i <= 5) expectBus($sformatf("chg%0d", i), 8'h00, 1'b0);
            else        expectBus($sformatf("chg%0d", i), 8'(8'h50 + i - 5), 1'b1);
        end

        // Delay change on an idle cycle: dout holds, penalty of D_new enables
        applyStimulus(1'b0, 1'b0, 4'd1, 8'hEE);
        expectBus("idlechg", 8'h55, 1'b0);
        checkOutput("idlechg_filled", 32'(bus.filled), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'd1, 8'h60);
        expectBus("idlechg_a", 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd1, 8'h61);
        expectBus("idlechg_b", 8'h60, 1'b1);

        // clr while valid, together with en and a new delay: clr wins
        applyStimulus(1'b1, 1'b1, 4'd2, 8'h77);
        expectBus("clr", 8'h00, 1'b0);
        checkOutput("clr_filled", 32'(bus.filled), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'd2, 8'h78);
        expectBus("clr_a", 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd2, 8'h79);
        expectBus("clr_b", 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd2, 8'h7A);
        expectBus("clr_c", 8'h78, 1'b1);

        // Asynchronous reset mid-stream, away from any clock edge
        applyStimulus(1'b1, 1'b0, 4'd2, 8'h7B);
        expectBus("prerst", 8'h79, 1'b1);
        bus.delay = 4'd0;
        #2;
        rst = 1'b1;
        #1;
        expectBus("asyncrst", 8'h00, 1'b0);
        checkOutput("asyncrst_filled", 32'(bus.filled), 32'd1);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h34);
        expectBus("postrst", 8'h34, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
